// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer.
// Holds the controller state encoding and the two shift-direction codes.
// Both rtl/sseq_shift_reg.sv and rtl/shift_seq_ctrl.sv import this package.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_TO_MSB = 1'b0;  // d enters bit 0
  localparam logic DIR_TO_LSB = 1'b1;  // d enters bit WIDTH-1

endpackage

// File: rtl/sseq_shift_reg.sv
// Purpose: WIDTH-bit bidirectional serial-in shift register.
// Latency: q reflects a shift one edge after en=1; no backpressure (holds when en=0).
// Ports: clk, rst (sync, active-high) | en, dir, d (shift control) | q (contents).
module sseq_shift_reg
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      if (dir == DIR_TO_LSB) begin
        q_d = {d, q_q[WIDTH-1:1]};
      end else begin
        q_d = {q_q[WIDTH-2:0], d};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Purpose: command-driven sequencer serialising cmd_data into a shift register, one shift per cycle.
// Latency: accept at edge A, shifts at A+1..A+N, done in the cycle after A+N (count=0: cycle after A).
// Backpressure: cmd_ready is high only in IDLE; commands are held off while a shift sequence runs.
// Ports: clk, rst (sync, active-high) | cmd_valid/cmd_ready/cmd_dir/cmd_count/cmd_data (command)
//        abort | busy, done (status) | sr_en, sr_dir, sr_d (register drive) | q (register contents).
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_d,
  output logic [WIDTH-1:0] q
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;   // shifts still to issue
  logic [CNT_W-1:0] idx_q, idx_d;   // index k of the next serial bit
  logic             sel_bit;

  // Serial bit for index k: MSB-first toward MSB, LSB-first toward LSB.
  // Indices past the word width fall through to the 0 default.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx_q == CNT_W'(i)) begin
        sel_bit = (dir_q == DIR_TO_LSB) ? data_q[i] : data_q[WIDTH-1-i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    data_d    = data_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    sr_en     = 1'b0;
    sr_dir    = 1'b0;
    sr_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          data_d  = cmd_data;
          rem_d   = cmd_count;
          idx_d   = '0;
          state_d = (cmd_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sr_dir = dir_q;
        sr_d   = sel_bit;
        if (abort) begin
          // Leave q with whatever was shifted so far; no done pulse.
          state_d = IDLE;
        end else begin
          sr_en = 1'b1;
          idx_d = idx_q + CNT_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      data_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  sseq_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk(clk),
    .rst(rst),
    .en (sr_en),
    .dir(sr_dir),
    .d  (sr_d),
    .q  (q)
  );

endmodule
